// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm controller slice.
// Day indices, time-code width and FSM state encoding.
package alarm_pkg;

    localparam int TIME_W             = 13;
    localparam int DAY_W              = 3;
    localparam int NUM_DAYS           = 7;
    localparam int RING_MINUTES_DEF   = 5;
    localparam int SNOOZE_MINUTES_DEF = 9;
    localparam int MAX_SNOOZE_DEF     = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2,
        HOLD   = 2'd3
    } alarm_state_t;

endpackage

// File: rtl/alarm_reg_file.sv
// Per-day alarm time registers, enable mask and write handshake.
// Writes to day 7 are rejected with a one-cycle error pulse.
module alarm_reg_file
    import alarm_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_set_req,
    input  logic [DAY_W-1:0]                   i_set_day,
    input  logic [TIME_W-1:0]                  i_set_time,
    input  logic                               i_set_enable,
    output logic [NUM_DAYS-1:0][TIME_W-1:0]    o_alarm,
    output logic [NUM_DAYS-1:0]                o_day_en,
    output logic                               o_set_ack,
    output logic                               o_set_err
);

    logic [NUM_DAYS-1:0][TIME_W-1:0] r_alarm;
    logic [NUM_DAYS-1:0]             r_day_en;
    logic                            r_set_ack;
    logic                            r_set_err;
    logic                            w_day_ok;

    assign w_day_ok = (i_set_day < DAY_W'(NUM_DAYS));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alarm   <= '0;
            r_day_en  <= '0;
            r_set_ack <= 1'b0;
            r_set_err <= 1'b0;
        end else begin
            r_set_ack <= i_set_req && w_day_ok;
            r_set_err <= i_set_req && !w_day_ok;
            if (i_set_req && w_day_ok) begin
                r_alarm[i_set_day]  <= i_set_time;
                r_day_en[i_set_day] <= i_set_enable;
            end
        end
    end

    assign o_alarm   = r_alarm;
    assign o_day_en  = r_day_en;
    assign o_set_ack = r_set_ack;
    assign o_set_err = r_set_err;

endmodule

// File: rtl/alarm_controller.sv
// Alarm sequencer: owns per-day alarm config and the ring/snooze/stop FSM.
// Outputs are registered from the next-state so buzzer follows match by one cycle.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int RING_MINUTES   = RING_MINUTES_DEF,
    parameter int SNOOZE_MINUTES = SNOOZE_MINUTES_DEF,
    parameter int MAX_SNOOZE     = MAX_SNOOZE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              minute_tick,
    input  logic [DAY_W-1:0]  cur_day,
    input  logic              alarm_match,
    input  logic              set_req,
    input  logic [DAY_W-1:0]  set_day,
    input  logic [TIME_W-1:0] set_time,
    input  logic              set_enable,
    input  logic              snooze_btn,
    input  logic              stop_btn,
    output logic [TIME_W-1:0] alarm_r0,
    output logic [TIME_W-1:0] alarm_r1,
    output logic [TIME_W-1:0] alarm_r2,
    output logic [TIME_W-1:0] alarm_r3,
    output logic [TIME_W-1:0] alarm_r4,
    output logic [TIME_W-1:0] alarm_r5,
    output logic [TIME_W-1:0] alarm_r6,
    output logic [6:0]        day_en,
    output logic              set_ack,
    output logic              set_err,
    output logic              buzzer,
    output logic              snoozing,
    output logic [1:0]        snooze_cnt
);

    localparam int TMR_MAX = (RING_MINUTES > SNOOZE_MINUTES) ?
                             RING_MINUTES : SNOOZE_MINUTES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    logic [NUM_DAYS-1:0][TIME_W-1:0] w_alarm;
    logic [NUM_DAYS-1:0]             w_day_en;
    logic                            w_day_en_cur;

    alarm_state_t     r_state;
    alarm_state_t     w_state_nxt;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_nxt;
    logic [TMR_W-1:0] w_timer_inc;
    logic [1:0]       r_snooze_cnt;
    logic [1:0]       w_cnt_nxt;
    logic             r_buzzer;
    logic             r_snoozing;

    alarm_reg_file u_regs (
        .clk          (clk),
        .rst          (rst),
        .i_set_req    (set_req),
        .i_set_day    (set_day),
        .i_set_time   (set_time),
        .i_set_enable (set_enable),
        .o_alarm      (w_alarm),
        .o_day_en     (w_day_en),
        .o_set_ack    (set_ack),
        .o_set_err    (set_err)
    );

    assign alarm_r0 = w_alarm[0];
    assign alarm_r1 = w_alarm[1];
    assign alarm_r2 = w_alarm[2];
    assign alarm_r3 = w_alarm[3];
    assign alarm_r4 = w_alarm[4];
    assign alarm_r5 = w_alarm[5];
    assign alarm_r6 = w_alarm[6];
    assign day_en   = w_day_en;

    // Pre-write enable: a same-cycle write only lands at the next edge.
    assign w_day_en_cur = (cur_day < DAY_W'(NUM_DAYS)) ?
                          w_day_en[cur_day] : 1'b0;
    assign w_timer_inc  = r_timer + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_cnt_nxt   = r_snooze_cnt;
        unique case (r_state)
            IDLE: begin
                w_timer_nxt = '0;
                w_cnt_nxt   = '0;
                if (alarm_match && w_day_en_cur) begin
                    w_state_nxt = RING;
                end
            end
            RING: begin
                if (stop_btn) begin
                    w_state_nxt = HOLD;
                    w_timer_nxt = '0;
                end else if (snooze_btn &&
                             (r_snooze_cnt < 2'(MAX_SNOOZE))) begin
                    w_state_nxt = SNOOZE;
                    w_cnt_nxt   = r_snooze_cnt + 2'd1;
                    w_timer_nxt = '0;
                end else if (minute_tick) begin
                    if (w_timer_inc == TMR_W'(RING_MINUTES)) begin
                        w_state_nxt = HOLD;
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = w_timer_inc;
                    end
                end
            end
            SNOOZE: begin
                if (stop_btn) begin
                    w_state_nxt = HOLD;
                    w_timer_nxt = '0;
                end else if (minute_tick) begin
                    if (w_timer_inc == TMR_W'(SNOOZE_MINUTES)) begin
                        w_state_nxt = RING;
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = w_timer_inc;
                    end
                end
            end
            HOLD: begin
                w_timer_nxt = '0;
                if (!alarm_match) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_timer_nxt = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_timer      <= '0;
            r_snooze_cnt <= '0;
            r_buzzer     <= 1'b0;
            r_snoozing   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_snooze_cnt <= w_cnt_nxt;
            r_buzzer     <= (w_state_nxt == RING);
            r_snoozing   <= (w_state_nxt == SNOOZE);
        end
    end

    assign buzzer     = r_buzzer;
    assign snoozing   = r_snoozing;
    assign snooze_cnt = r_snooze_cnt;

endmodule
